// File: rtl/bit_serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder slice reused over WIDTH cycles,
// LSB first, with an IDLE/RUN/DONE sequencer and registered {co,s} result.
module bit_serial_add_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic [1:0]       state_dbg
);

    // Handshake: start is a request sampled on each rising edge; it is taken
    // only in IDLE or DONE, and a/b/ci are captured on that same edge. done is
    // a one-cycle pulse during which s/co hold the fresh result.

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic             c;
    logic [CW-1:0]    cnt;

    logic             slice_s;
    logic             slice_c;
    logic [WIDTH:0]   s_cat;
    logic             accept;

    // The only adder in the datapath: a single 1-bit full-adder slice.
    assign {slice_c, slice_s} = {1'b0, a_sh[0]} + {1'b0, b_sh[0]} + {1'b0, c};

    // New sum bit enters at the MSB; the upper WIDTH bits are the shifted value.
    assign s_cat  = {slice_s, s_sh};
    assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));

    assign busy      = (state == ST_RUN);
    assign done      = (state == ST_DONE);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= ST_IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            s     <= '0;
            co    <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    s_sh <= s_cat[WIDTH:1];
                    c    <= slice_c;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        s     <= s_cat[WIDTH:1];
                        co    <= slice_c;
                        state <= ST_DONE;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request; DONE otherwise
                    // falls back to IDLE after its single cycle.
                    if (accept) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        c     <= ci;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_add_ctrl.sv
// Directed + randomized bench for bit_serial_add_ctrl at WIDTH=8 and WIDTH=1,
// results compared against plain arithmetic (a + b + ci).
module tb_bit_serial_add_ctrl;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // WIDTH=8 instance
    logic         clrn8 = 1'b1;
    logic         start8 = 1'b0;
    logic [W-1:0] a8 = '0;
    logic [W-1:0] b8 = '0;
    logic         ci8 = 1'b0;
    logic         busy8, done8, co8;
    logic [W-1:0] s8;
    logic [1:0]   st8;

    // WIDTH=1 instance
    logic       clrn1 = 1'b1;
    logic       start1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       ci1 = 1'b0;
    logic       busy1, done1, co1;
    logic [0:0] s1;
    logic [1:0] st1;

    logic [W:0] last8 = '0;
    logic [1:0] last1 = '0;

    bit_serial_add_ctrl #(.WIDTH(W)) dut8 (
        .clk(clk), .clrn(clrn8), .start(start8), .a(a8), .b(b8), .ci(ci8),
        .busy(busy8), .done(done8), .s(s8), .co(co8), .state_dbg(st8)
    );

    bit_serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .clrn(clrn1), .start(start1), .a(a1), .b(b1), .ci(ci1),
        .busy(busy1), .done(done1), .s(s1), .co(co1), .state_dbg(st1)
    );

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs from just after the accepting edge until done is seen (bounded).
    // inj >= 0 drives a one-cycle stray start with other operands at that cycle.
    task automatic wait_done8(input int inj, output int n, output int busy_cnt, output int hold_bad);
        n = 0; busy_cnt = 0; hold_bad = 0;
        while (done8 !== 1'b1 && n < 4 * W) begin
            if (busy8 === 1'b1) busy_cnt++;
            if ({co8, s8} !== last8) hold_bad++;
            if (inj >= 0) begin
                if (n == inj) begin
                    start8 = 1'b1; a8 = 8'h11; b8 = 8'h22; ci8 = 1'b0;
                end else begin
                    start8 = 1'b0;
                end
            end
            tick();
            n++;
        end
    endtask

    task automatic add8(input logic [W-1:0] av, input logic [W-1:0] bv, input logic civ,
                        input int inj, input string tag);
        logic [W:0] exp;
        int n, bc, hb;
        exp = (W+1)'(av) + (W+1)'(bv) + (W+1)'(civ);
        start8 = 1'b1; a8 = av; b8 = bv; ci8 = civ;
        tick();
        start8 = 1'b0; a8 = W'($urandom); b8 = W'($urandom); ci8 = 1'($urandom);
        wait_done8(inj, n, bc, hb);
        check({tag, " latency"}, 65'(n), 65'(W));
        check({tag, " busy_cycles"}, 65'(bc), 65'(W));
        check({tag, " hold"}, 65'(hb), 65'(0));
        check({tag, " result"}, 65'({co8, s8}), 65'(exp));
        last8 = exp;
    endtask

    task automatic add1(input logic av, input logic bv, input logic civ, input string tag);
        logic [1:0] exp;
        int n;
        exp = 2'(av) + 2'(bv) + 2'(civ);
        start1 = 1'b1; a1 = av; b1 = bv; ci1 = civ;
        tick();
        start1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom); ci1 = 1'($urandom);
        check({tag, " busy"}, 65'(busy1), 65'(1));
        check({tag, " hold"}, 65'({co1, s1}), 65'(last1));
        n = 0;
        while (done1 !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 65'(n), 65'(1));
        check({tag, " result"}, 65'({co1, s1}), 65'(exp));
        last1 = exp;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, bc, hb, dones;
        logic [W-1:0] ra, rb;
        logic rc;

        // Asynchronous reset before any clock edge, with junk on the inputs.
        start8 = 1'b1; a8 = W'($urandom); b8 = W'($urandom); ci8 = 1'($urandom);
        start1 = 1'b1; a1 = 1'($urandom); b1 = 1'($urandom); ci1 = 1'($urandom);
        #1 clrn8 = 1'b0; clrn1 = 1'b0;
        #1;
        check("rst busy", 65'(busy8), 65'(0));
        check("rst done", 65'(done8), 65'(0));
        check("rst s", 65'(s8), 65'(0));
        check("rst co", 65'(co8), 65'(0));
        check("rst w1 outputs", 65'({busy1, done1, co1, s1}), 65'(0));
        repeat (3) tick();
        check("rst held busy", 65'(busy8), 65'(0));
        check("rst held state", 65'(st8), 65'(0));
        start8 = 1'b0; start1 = 1'b0;
        clrn8 = 1'b1; clrn1 = 1'b1;

        // First edge with start after reset release is accepted; carry ripple.
        add8(8'hFF, 8'h01, 1'b0, -1, "ripple");
        tick();
        check("ripple done_pulse", 65'(done8), 65'(0));

        add8(8'h5A, 8'h33, 1'b1, -1, "carry_in");
        tick();

        // Stray start mid-RUN must not disturb the addition in flight.
        add8(8'h80, 8'h80, 1'b0, 3, "ignored_start");
        dones = 0;
        for (int i = 0; i < 3 * W; i++) begin
            tick();
            if (done8 === 1'b1) dones++;
        end
        check("ignored_start extra_done", 65'(dones), 65'(0));
        check("ignored_start idle", 65'(st8), 65'(0));
        check("ignored_start s_kept", 65'({co8, s8}), 65'(last8));

        // Back-to-back with start held high.
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; ci8 = 1'b0;
        tick();
        a8 = 8'hF0; b8 = 8'h0F; ci8 = 1'b1;
        wait_done8(-1, n, bc, hb);
        check("b2b first latency", 65'(n), 65'(W));
        check("b2b first result", 65'({co8, s8}), 65'(9'h002));
        last8 = 9'h002;
        tick();
        start8 = 1'b0; a8 = 8'hAA; b8 = 8'h55; ci8 = 1'b0;
        wait_done8(-1, n, bc, hb);
        check("b2b gap", 65'(n + 1), 65'(W + 1));
        check("b2b second hold", 65'(hb), 65'(0));
        check("b2b second result", 65'({co8, s8}), 65'(9'h100));
        last8 = 9'h100;
        tick();

        // Mid-operation reset, four cycles after the accepting edge.
        start8 = 1'b1; a8 = 8'hC3; b8 = 8'h7E; ci8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (4) tick();
        check("midrst busy_before", 65'(busy8), 65'(1));
        #2 clrn8 = 1'b0;
        #1;
        check("midrst async outputs", 65'({busy8, done8, co8, s8}), 65'(0));
        check("midrst state", 65'(st8), 65'(0));
        #1 clrn8 = 1'b1;
        last8 = '0;
        dones = 0;
        for (int i = 0; i < 2 * W; i++) begin
            tick();
            if (done8 === 1'b1) dones++;
        end
        check("midrst no_done", 65'(dones), 65'(0));
        check("midrst s_zero", 65'({co8, s8}), 65'(0));
        add8(8'h03, 8'h04, 1'b0, -1, "after_rst");
        tick();

        // Randomized additions with random idle gaps.
        for (int k = 0; k < 25; k++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            add8(ra, rb, rc, -1, "random");
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                tick();
                check("random idle", 65'({busy8, done8}), 65'(0));
            end
        end

        // WIDTH=1: mid-op reset, then every operand combination.
        start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("w1 midrst busy_before", 65'(busy1), 65'(1));
        #2 clrn1 = 1'b0;
        #1;
        check("w1 midrst outputs", 65'({busy1, done1, co1, s1}), 65'(0));
        #1 clrn1 = 1'b1;
        last1 = '0;
        tick();
        check("w1 midrst no_done", 65'(done1), 65'(0));
        add1(1'b1, 1'b1, 1'b0, "w1 two_operand");
        tick();
        for (int v = 0; v < 8; v++) begin
            add1(v[0], v[1], v[2], "w1 exhaustive");
        end
        tick();
        check("w1 final idle", 65'(st1), 65'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
